// File: rtl/risc_pkg.sv
// Opcode codes, controller state encoding and decode helpers shared by the
// RISC controller family.
package risc_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8,
        FAULT      = 4'd9
    } state_t;

    // Operations that read an operand from memory into the accumulator path.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational strobe decode from controller state and opcode; also used by
// the legacy 8-phase controller.
module risc_ctrl_decode
    import risc_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  state_t           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             is_zero,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             halt,
    output logic             inc_pc,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             wr,
    output logic             data_e
);

    logic       legal;
    logic [2:0] op3;
    logic       op_hlt;
    logic       op_skz;
    logic       op_sto;
    logic       op_jmp;
    logic       op_alu;

    // Widened opcodes are only legal when every bit above the classic 3 is zero.
    assign legal  = (opcode >> 3) == '0;
    assign op3    = opcode[2:0];
    assign op_hlt = legal && (op3 == HLT);
    assign op_skz = legal && (op3 == SKZ);
    assign op_sto = legal && (op3 == STO);
    assign op_jmp = legal && (op3 == JMP);
    assign op_alu = legal && is_aluop(op3);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        case (state)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = op_hlt || !legal;
            end
            OP_FETCH: rd = op_alu;
            ALU_OP: begin
                rd     = op_alu;
                inc_pc = op_skz && is_zero;
                ld_pc  = op_jmp;
                data_e = op_sto;
            end
            STORE: begin
                rd     = op_alu;
                ld_ac  = op_alu;
                inc_pc = op_jmp;
                ld_pc  = op_jmp;
                wr     = op_sto;
                data_e = op_sto;
            end
            HALTED: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/risc_ctrl_ws.sv
// RISC controller with memory wait states, bus timeout fault, resumable halt
// and illegal-opcode detection. Define RISC_CTRL_STAT_EN to add instr_cnt.
module risc_ctrl_ws
    import risc_pkg::*;
#(
    parameter int OPC_W    = 3,
    parameter int TIMEOUT  = 15,
    parameter int WS_CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             is_zero,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             halt,
    output logic             inc_pc,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             wr,
    output logic             data_e,
    output logic             bus_err,
    output logic             illegal_op,
    output logic [3:0]       state_o
`ifdef RISC_CTRL_STAT_EN
    ,
    output logic [31:0]      instr_cnt
`endif
);

    localparam logic                TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [WS_CNT_W-1:0] TIMEOUT_CNT = WS_CNT_W'(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic [WS_CNT_W-1:0] wait_cnt;
    logic [WS_CNT_W-1:0] wait_cnt_next;
    logic                illegal_q;
    logic                illegal_next;
    logic                legal;
    logic                op_hlt;
    logic                op_sto;
    logic                op_alu;
    logic                in_wait;

    assign legal   = (opcode >> 3) == '0;
    assign op_hlt  = legal && (opcode[2:0] == HLT);
    assign op_sto  = legal && (opcode[2:0] == STO);
    assign op_alu  = legal && is_aluop(opcode[2:0]);
    assign in_wait = (state == INST_FETCH)
                  || (state == OP_FETCH && op_alu)
                  || (state == STORE && op_sto);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INST_ADDR;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            illegal_q <= illegal_next;
        end
    end

    // A stalled wait state holds until ready; the stall budget exhausted sends it to FAULT.
    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        illegal_next  = illegal_q;
        if (in_wait && !mem_ready) begin
            if (TIMEOUT_EN && wait_cnt == TIMEOUT_CNT) begin
                state_next = FAULT;
            end else begin
                wait_cnt_next = wait_cnt + 1'b1;
            end
        end else begin
            case (state)
                INST_ADDR:  state_next = INST_FETCH;
                INST_FETCH: state_next = INST_LOAD;
                INST_LOAD:  state_next = IDLE;
                IDLE:       state_next = OP_ADDR;
                OP_ADDR: begin
                    illegal_next = !legal;
                    state_next   = (op_hlt || !legal) ? HALTED : OP_FETCH;
                end
                OP_FETCH:   state_next = ALU_OP;
                ALU_OP:     state_next = STORE;
                STORE:      state_next = INST_ADDR;
                HALTED: begin
                    if (resume) begin
                        state_next   = INST_ADDR;
                        illegal_next = 1'b0;
                    end
                end
                FAULT:      state_next = FAULT;
                default:    state_next = INST_ADDR;
            endcase
        end
    end

`ifdef RISC_CTRL_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt <= '0;
        end else if ((state == STORE && state_next == INST_ADDR)
                  || (state != HALTED && state_next == HALTED)) begin
            instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

    risc_ctrl_decode #(
        .OPC_W(OPC_W)
    ) u_decode (
        .state  (state),
        .opcode (opcode),
        .is_zero(is_zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e)
    );

    assign bus_err    = (state == FAULT);
    assign illegal_op = illegal_q;
    assign state_o    = state;

endmodule

// File: tb/tb_risc_ctrl_ws.sv
// Self-checking bench for risc_ctrl_ws: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_risc_ctrl_ws;

    localparam int OPC_W    = 4;
    localparam int TIMEOUT  = 4;
    localparam int WS_CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       is_zero;
    logic       mem_ready;
    logic       resume;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic       bus_err;
    logic       illegal_op;
    logic [3:0] state_o;
`ifdef RISC_CTRL_STAT_EN
    logic [31:0] instr_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: phase number 0..9, stall length, illegal flag, retire count.
    int          m_state;
    int          m_stall;
    bit          m_ill;
    bit          m_valid = 1'b0;
    int unsigned m_cnt;

    risc_ctrl_ws #(
        .OPC_W   (OPC_W),
        .TIMEOUT (TIMEOUT),
        .WS_CNT_W(WS_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .is_zero   (is_zero),
        .mem_ready (mem_ready),
        .resume    (resume),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .halt      (halt),
        .inc_pc    (inc_pc),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .wr        (wr),
        .data_e    (data_e),
        .bus_err   (bus_err),
        .illegal_op(illegal_op),
        .state_o   (state_o)
`ifdef RISC_CTRL_STAT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_legal(input logic [3:0] op);
        return op < 4'd8;
    endfunction

    function automatic bit m_alu(input logic [3:0] op);
        return op >= 4'd2 && op <= 4'd5;
    endfunction

    // Strobe vector order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
    function automatic logic [8:0] exp_strobes(input int st, input logic [3:0] op, input logic z);
        logic [8:0] v;
        v = '0;
        case (st)
            0: v[8] = 1'b1;
            1: v[8:7] = 2'b11;
            2, 3: v[8:6] = 3'b111;
            4: begin
                v[4] = 1'b1;
                v[5] = (op == 4'd0) || !m_legal(op);
            end
            5: v[7] = m_alu(op);
            6: begin
                v[7] = m_alu(op);
                v[4] = (op == 4'd1) && z;
                v[2] = (op == 4'd7);
                v[0] = (op == 4'd6);
            end
            7: begin
                v[7] = m_alu(op);
                v[3] = m_alu(op);
                v[4] = (op == 4'd7);
                v[2] = (op == 4'd7);
                v[1] = (op == 4'd6);
                v[0] = (op == 4'd6);
            end
            8: v[5] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] op, input logic z,
                                 input logic rdy, input logic res);
        #1;
        rst       = r;
        opcode    = op;
        is_zero   = z;
        mem_ready = rdy;
        resume    = res;
    endtask

    // Model advances on each rising edge from the inputs presented to that edge.
    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_stall <= 0;
            m_ill   <= 1'b0;
            m_cnt   <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (((m_state == 1) || (m_state == 5 && m_alu(opcode)) || (m_state == 7 && opcode == 4'd6))
                && !mem_ready) begin
                if (m_stall == TIMEOUT) m_state <= 9;
                else                    m_stall <= m_stall + 1;
            end else begin
                m_stall <= 0;
                case (m_state)
                    4: begin
                        if (opcode == 4'd0 || !m_legal(opcode)) begin
                            m_state <= 8;
                            m_ill   <= !m_legal(opcode);
                            m_cnt   <= m_cnt + 1;
                        end else begin
                            m_state <= 5;
                        end
                    end
                    7: begin
                        m_state <= 0;
                        m_cnt   <= m_cnt + 1;
                    end
                    8: begin
                        if (resume) begin
                            m_state <= 0;
                            m_ill   <= 1'b0;
                        end
                    end
                    9: ;
                    default: m_state <= m_state + 1;
                endcase
            end
        end
    end

    // Every falling edge after the first reset: DUT outputs must match the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("strobes", {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
                        exp_strobes(m_state, opcode, is_zero));
            checkOutput("state_o", state_o, m_state);
            checkOutput("bus_err", bus_err, m_state == 9);
            checkOutput("illegal_op", illegal_op, m_ill);
`ifdef RISC_CTRL_STAT_EN
            checkOutput("instr_cnt", instr_cnt, m_cnt);
`endif
        end
    end

    // Runs one instruction from INST_ADDR with mem_ready high until INST_ADDR or HALTED.
    task automatic runInstr(input logic [3:0] op, input logic z, output int cycles,
                            output int incs, output int ldpcs, output int ldacs, output int halts);
        cycles = 0; incs = 0; ldpcs = 0; ldacs = 0; halts = 0;
        applyStimulus(1'b0, op, z, 1'b1, 1'b0);
        while (cycles < 30) begin
            @(negedge clk);
            cycles++;
            incs  += int'(inc_pc);
            ldpcs += int'(ld_pc);
            ldacs += int'(ld_ac);
            halts += int'(halt);
            if (state_o == 4'd0 || state_o == 4'd8) break;
        end
        checkOutput("instr_bound", cycles < 30, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, incs, ldpcs, ldacs, halts, n, cnt, wrs, burst;
        rst = 1'b1; opcode = 4'd2; is_zero = 1'b0; mem_ready = 1'b1; resume = 1'b0;

        // Reset state, then one ADD with no stalls
        @(negedge clk);
        checkOutput("rst_state", state_o, 0);
        checkOutput("rst_strobes", {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}, 9'b100000000);
        checkOutput("rst_bus_err", bus_err, 0);
        checkOutput("rst_illegal", illegal_op, 0);
        runInstr(4'd2, 1'b0, cyc, incs, ldpcs, ldacs, halts);
        checkOutput("add_cycles", cyc, 8);
        checkOutput("add_ld_ac", ldacs, 1);
        checkOutput("add_end_state", state_o, 0);

        // ADD with three not-ready cycles in INST_FETCH
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        n = 0; cnt = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (state_o == 4'd1) begin
                cnt++;
                checkOutput("fetch_sel_rd", {sel, rd}, 2'b11);
                if (cnt == 4) applyStimulus(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
            end
            if (state_o == 4'd0) break;
        end
        checkOutput("stall_cycles", n, 11);
        checkOutput("stall_fetch", cnt, 4);
        checkOutput("stall_bus_err", bus_err, 0);

        // mem_ready stuck low: five INST_FETCH cycles then FAULT
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        n = 0; cnt = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (state_o == 4'd1) cnt++;
            if (state_o == 4'd9) break;
        end
        checkOutput("to_fetch_cycles", cnt, 5);
        checkOutput("to_state", state_o, 9);
        checkOutput("to_bus_err", bus_err, 1);
        repeat (3) @(negedge clk);
        checkOutput("to_held", {bus_err, state_o}, 5'h19);
        checkOutput("to_strobes", {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}, 0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("to_rst_state", state_o, 0);
        checkOutput("to_rst_bus_err", bus_err, 0);
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);

        // HLT: halt held, resume returns to INST_ADDR
        runInstr(4'd0, 1'b0, cyc, incs, ldpcs, ldacs, halts);
        checkOutput("hlt_state", state_o, 8);
        checkOutput("hlt_inc_pc", incs, 1);
        checkOutput("hlt_halt", halts, 2);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (halt && state_o == 4'd8) cnt++;
        end
        checkOutput("hlt_hold", cnt, 20);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("resume_state", state_o, 0);
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);

        // SKZ both flag values, then JMP
        runInstr(4'd1, 1'b1, cyc, incs, ldpcs, ldacs, halts);
        checkOutput("skz_z1_inc", incs, 2);
        runInstr(4'd1, 1'b0, cyc, incs, ldpcs, ldacs, halts);
        checkOutput("skz_z0_inc", incs, 1);
        runInstr(4'd7, 1'b0, cyc, incs, ldpcs, ldacs, halts);
        checkOutput("jmp_ld_pc", ldpcs, 2);
        checkOutput("jmp_inc_pc", incs, 2);

        // Illegal widened opcode halts with illegal_op
        runInstr(4'b1010, 1'b0, cyc, incs, ldpcs, ldacs, halts);
        checkOutput("ill_state", state_o, 8);
        checkOutput("ill_flag", illegal_op, 1);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("ill_cleared", {illegal_op, state_o}, 5'h00);

        // STO with two not-ready cycles in STORE
        applyStimulus(1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
        n = 0; cnt = 0; wrs = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (state_o == 4'd7) begin
                cnt++;
                if (wr && data_e) wrs++;
                if (cnt == 1) applyStimulus(1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
                if (cnt == 3) applyStimulus(1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
            end
            if (state_o == 4'd0) break;
        end
        checkOutput("sto_wr_cycles", wrs, 3);

        // Reset in the middle of a fetch stall
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        n = 0; cnt = 0;
        while (n < 20 && cnt < 2) begin
            @(negedge clk);
            n++;
            if (state_o == 4'd1) cnt++;
        end
        checkOutput("midstall_reached", cnt, 2);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("midstall_rst", state_o, 0);
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);

        // Randomized traffic, checked every cycle by the model compare process
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (state_o == 4'd0 || state_o == 4'd1 || state_o == 4'd8 || state_o == 4'd9)
                opcode = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            is_zero = 1'($urandom_range(0, 1));
            if (burst > 0) begin
                mem_ready = 1'b0;
                burst--;
            end else begin
                mem_ready = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 40) == 0) burst = $urandom_range(3, 7);
            end
            resume = ($urandom_range(0, 7) == 0);
            if (state_o == 4'd9) rst = ($urandom_range(0, 15) == 0);
            else                 rst = ($urandom_range(0, 299) == 0);
        end
        applyStimulus(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/risc_ctrl_ws.md
Name: risc_ctrl_ws

Overview:
Parametrised successor to the 8-phase RISC CPU controller: same opcode set (HLT/SKZ/ADD/AND/XOR/LDA/STO/JMP) and the same datapath control strobes. Adds memory wait-state handshake, bus-timeout fault, a held HALT state with resume, and illegal-opcode detection for widened opcodes. Sits between the instruction register/accumulator flags and the PC, IR, AC and memory bus.

Parameters:
OPC_W, 3, opcode width (>=3); codes with any bit above bit 2 set are illegal.
TIMEOUT, 15, max consecutive not-ready cycles in a wait state before fault; 0 disables the timeout.
WS_CNT_W, 4, wait counter width; must hold TIMEOUT.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
opcode  in  OPC_W  current IR opcode, stable from INST_LOAD onward
is_zero  in  1  accumulator zero flag
mem_ready  in  1  memory ready; read data valid / write accepted
resume  in  1  single-cycle pulse to leave HALTED
sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e  out  1 each  datapath strobes, same meaning as the 8-phase controller
bus_err  out  1  sticky timeout fault
illegal_op  out  1  high in HALTED when the halt was caused by an illegal opcode
state_o  out  4  current state encoding, debug

Behaviour:
- Decoding: ALUOP = ADD|AND|XOR|LDA. Opcode compare uses the full OPC_W bits.
- States: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED, FAULT. 4-bit registered state. Outputs are a combinational decode of state and opcode (Moore on state).
- Output decode:
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD and IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc=1; halt=HLT|illegal.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=SKZ&is_zero; ld_pc=JMP; data_e=STO.
  - STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=JMP; ld_pc=JMP; wr=STO; data_e=STO.
  - HALTED: halt=1, all other strobes 0.
  - FAULT: all strobes 0, bus_err=1.
- Transitions: the fixed sequence INST_ADDR through STORE, then back to INST_ADDR.
  - OP_ADDR with HLT or illegal opcode goes to HALTED instead of OP_FETCH.
  - HALTED goes to INST_ADDR on resume=1, otherwise holds.
  - FAULT holds until rst.
- Wait states: INST_FETCH always, OP_FETCH when ALUOP, STORE when STO.
  - In a wait state with mem_ready=0: state holds and outputs stay asserted.
  - With mem_ready=1: advance.
  - In non-wait phases mem_ready is ignored.
- Timeout: wait_cnt clears on every state change.
  - Each held cycle: if TIMEOUT!=0 and wait_cnt==TIMEOUT, next state is FAULT; else wait_cnt increments.
  - Result: at most TIMEOUT stall cycles, and the (TIMEOUT+1)-th not-ready cycle enters FAULT.
- Reset: the next edge with rst=1 sets state=INST_ADDR, wait_cnt=0 and clears the illegal latch.
  - Post-reset outputs: sel=1, all other strobes, bus_err and illegal_op = 0, state_o=0.
  - rst overrides everything, including mid-stall, HALTED and FAULT.
- Simultaneous events:
  - resume outside HALTED is ignored.
  - resume with rst: rst wins.
  - mem_ready going high on the timeout cycle: the advance wins and there is no fault.
- illegal_op: latched in OP_ADDR, cleared on leaving HALTED.

Optional Feature:
RISC_CTRL_STAT_EN
- Defined: adds output instr_cnt[31:0].
  - Increments on each transition from STORE to INST_ADDR and on each entry to HALTED.
  - Cleared by rst; wraps at 2^32-1 to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package risc_pkg holds:
  - opcode localparams (HLT=0 through JMP=7);
  - state enum/encoding (INST_ADDR=0 through STORE=7, HALTED=8, FAULT=9);
  - function is_aluop().
- Sub-module risc_ctrl_decode: purely combinational; state, opcode and is_zero in, nine strobes out. It is shared with the legacy 8-phase controller.

Test Plan:
1. rst for 1 cycle, ADD, mem_ready=1 -> 8 cycles per instruction; ld_ac=1 only in STORE; the INST_ADDR return occurs 8 cycles after the reset release.
2. ADD, mem_ready held 0 for 3 cycles in INST_FETCH -> sel=rd=1 hold for 4 cycles; the instruction takes 11 cycles; no bus_err.
3. TIMEOUT=4, mem_ready stuck 0 -> exactly 5 cycles in INST_FETCH, then FAULT with bus_err=1 held. A later rst gives INST_ADDR with bus_err=0.
4. HLT -> inc_pc and halt in OP_ADDR, then HALTED with halt=1 for 20 cycles; a resume pulse gives INST_ADDR on the next edge.
5. SKZ with is_zero=1 -> inc_pc in OP_ADDR and ALU_OP (2 pulses). With is_zero=0 -> 1 pulse. JMP -> ld_pc in ALU_OP and STORE.
6. OPC_W=4, opcode=4'b1010 -> HALTED with illegal_op=1. STO with mem_ready 0 for 2 cycles in STORE -> wr and data_e held 3 cycles. rst mid-stall -> INST_ADDR.
